// File: rtl/npu_pkg.sv
// npu_pkg: shared NPU definitions for the final carry-propagate adder path.
//   ADD_W          - width of adder_final (columns i6..i19)
//   N_REQ_DEFAULT  - default number of lanes sharing one adder
//   TAG_W_DEFAULT  - lane-index width for the default lane count
//   rows_to_cols() - maps a carry-save row pair onto adder_final column inputs
package npu_pkg;

    localparam int ADD_W         = 14;
    localparam int N_REQ_DEFAULT = 4;
    localparam int TAG_W_DEFAULT = 2;
    // Index of the lowest column handled by adder_final (column i6).
    localparam int COL_LO        = 6;

    // One adder column: bit 0 from row a, bit 1 from row b.
    typedef logic [1:0]           col_t;
    // Element j is column i(j+COL_LO).
    typedef col_t [ADD_W-1:0]     cols_t;

    function automatic cols_t rows_to_cols(input logic [ADD_W-1:0] a,
                                           input logic [ADD_W-1:0] b);
        cols_t c;
        for (int j = 0; j < ADD_W; j++) begin
            c[j] = {b[j], a[j]};
        end
        return c;
    endfunction

endpackage

// File: rtl/adder_final.sv
// adder_final: 14-bit final carry-propagate adder of the compressor tree.
//   cols - column inputs i6..i19, two bits per column (row a in bit 0, row b in bit 1)
//   sum  - (row a + row b) mod 2^ADD_W; the carry out of the top column is dropped
module adder_final
    import npu_pkg::*;
(
    input  cols_t            cols,
    output logic [ADD_W-1:0] sum
);

    logic [ADD_W-1:0] row_a;
    logic [ADD_W-1:0] row_b;

    always_comb begin
        row_a = '0;
        row_b = '0;
        for (int j = 0; j < ADD_W; j++) begin
            row_a[j] = cols[j][0];
            row_b[j] = cols[j][1];
        end
    end

    assign sum = row_a + row_b;

endmodule

// File: rtl/adder_final_arb_rr_arb.sv
// rr_arb: round-robin grant with a rotating priority pointer.
//   clk, reset - clock and synchronous active-high reset
//   req_valid  - per-requester valid
//   en         - grant enable; a grant issued while en=1 is a transfer
//   ready      - one-hot (or zero) grant, already qualified by en
//   gnt_idx    - index of the selected requester (valid when gnt_any=1)
//   gnt_any    - some requester is selected (before en qualification)
module rr_arb #(
    parameter int N_REQ = 4,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req_valid,
    input  logic             en,
    output logic [N_REQ-1:0] ready,
    output logic [TAG_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [TAG_W-1:0] rr_ptr_q;
    logic [TAG_W-1:0] rr_ptr_d;

    // Scan rr_ptr, rr_ptr+1, ... and keep the first valid lane.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = (int'(rr_ptr_q) + off) % N_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = TAG_W'(idx);
            end
        end
    end

    always_comb begin
        ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            ready[k] = en && gnt_any && (gnt_idx == TAG_W'(k));
        end
    end

    // Priority moves just past the lane that transferred.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (en && gnt_any) begin
            if (gnt_idx == TAG_W'(N_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/adder_final_arb.sv
// adder_final_arb: round-robin shared front end for adder_final.
//   clk, reset           - clock and synchronous active-high reset
//   req_valid/req_ready  - per-lane handshake; req_ready is one-hot or zero
//   req_a/req_b          - per-lane carry-save rows, lane k at [k*ADD_W +: ADD_W]
//   out_valid/out_ready  - result handshake
//   out_data             - (a+b) mod 2^ADD_W
//   out_tag              - lane that produced the result
// S1 registers the winning operands and feeds adder_final; S2 registers the sum.
module adder_final_arb
    import npu_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*ADD_W-1:0] req_a,
    input  logic [N_REQ*ADD_W-1:0] req_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADD_W-1:0]       out_data,
    output logic [TAG_W-1:0]       out_tag
);

    logic             s1_valid_q, s1_valid_d;
    logic [ADD_W-1:0] s1_a_q, s1_a_d;
    logic [ADD_W-1:0] s1_b_q, s1_b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             out_valid_q, out_valid_d;
    logic [ADD_W-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic             s1_adv, s2_adv;
    logic             arb_en;
    logic [TAG_W-1:0] gnt_idx;
    logic             gnt_any;
    logic             xfer;
    cols_t            cols;
    logic [ADD_W-1:0] sum;

    assign s2_adv = !out_valid_q || out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    // Reset gates the grant so no lane sees an accept that is then discarded.
    assign arb_en = s1_adv && !reset;
    assign xfer   = gnt_any && arb_en;

    rr_arb #(
        .N_REQ (N_REQ),
        .TAG_W (TAG_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .en        (arb_en),
        .ready     (req_ready),
        .gnt_idx   (gnt_idx),
        .gnt_any   (gnt_any)
    );

    assign cols = rows_to_cols(s1_a_q, s1_b_q);

    adder_final u_add (
        .cols (cols),
        .sum  (sum)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_tag_d    = s1_tag_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;

        // S1 reloads whenever it advances; with no transfer it becomes a bubble.
        if (s1_adv) begin
            s1_valid_d = xfer;
            if (xfer) begin
                s1_a_d   = req_a[int'(gnt_idx)*ADD_W +: ADD_W];
                s1_b_d   = req_b[int'(gnt_idx)*ADD_W +: ADD_W];
                s1_tag_d = gnt_idx;
            end
        end

        // Data/tag only move on a real S1 item so they stay put across bubbles.
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = sum;
                out_tag_d  = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_tag_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_adder_final_arb.sv
module tb_adder_final_arb;

    localparam int N = 4;
    localparam int T = 2;
    localparam int W = 14;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [T-1:0]   out_tag;

    always #5 clk = ~clk;

    adder_final_arb #(.N_REQ(N), .TAG_W(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    // Per-lane operands held by the bench's requesters.
    logic [W-1:0] la [N];
    logic [W-1:0] lb [N];

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int k = 0; k < N; k++) begin
            req_a[k*W +: W] = la[k];
            req_b[k*W +: W] = lb[k];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model: in-order queue of accepted results plus a priority pointer.
    typedef struct {
        int d;
        int t;
    } exp_t;
    exp_t         q[$];
    int           mptr;
    bit           prev_hold;
    logic [W-1:0] prev_data;
    logic [T-1:0] prev_tag;
    logic [N-1:0] last_xfer;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] exp_grant(input logic [N-1:0] v, input int p);
        for (int off = 0; off < N; off++) begin
            int k;
            k = (p + off) % N;
            if (v[k]) return N'(1) << k;
        end
        return '0;
    endfunction

    // Called at the falling edge: checks outputs, then books this cycle's transfers.
    task automatic sample();
        int infl;
        bit can_acc;
        infl = q.size();
        if (reset) begin
            chk("ready_in_reset", req_ready, 0);
            last_xfer = '0;
            q.delete();
            mptr      = 0;
            prev_hold = 0;
            return;
        end
        // Both stages occupied and the output blocked: nothing can enter.
        can_acc = !(infl >= 2 && !out_ready);
        chk("req_ready", req_ready, can_acc ? exp_grant(req_valid, mptr) : N'(0));
        if (prev_hold) begin
            chk("hold_data", out_data, prev_data);
            chk("hold_tag", out_tag, prev_tag);
        end
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                chk("out_data", out_data, q[0].d);
                chk("out_tag", out_tag, q[0].t);
                if (out_ready) void'(q.pop_front());
            end
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        prev_tag  = out_tag;
        last_xfer = req_valid & req_ready;
        for (int k = 0; k < N; k++) begin
            if (last_xfer[k]) begin
                q.push_back('{(int'(la[k]) + int'(lb[k])) % 16384, k});
                mptr = (k + 1) % N;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        cycle();
        reset = 1'b0;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_tag", out_tag, 0);
    endtask

    task automatic drain();
        req_valid = '0;
        out_ready = 1'b1;
        repeat (4) cycle();
        chk("drain_empty", q.size(), 0);
    endtask

    typedef struct {
        int           lane;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vt[6];

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        mptr      = 0;
        prev_hold = 0;
        last_xfer = '0;
        for (int k = 0; k < N; k++) begin
            la[k] = '0;
            lb[k] = '0;
        end

        vt[0] = '{2, 14'h0005, 14'h0003, 14'h0008};
        vt[1] = '{0, 14'h3FFF, 14'h0001, 14'h0000};
        vt[2] = '{1, 14'h2000, 14'h2000, 14'h0000};
        vt[3] = '{3, 14'h1234, 14'h0F0F, 14'h2143};
        vt[4] = '{0, 14'h3FFF, 14'h3FFF, 14'h3FFE};
        vt[5] = '{3, 14'h0000, 14'h0000, 14'h0000};

        #1;
        do_reset();

        // Table: one lone request per vector, result exactly two cycles later.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            la[vt[i].lane] = vt[i].a;
            lb[vt[i].lane] = vt[i].b;
            req_valid      = N'(1) << vt[i].lane;
            out_ready      = 1'b1;
            cycle();
            chk("vec_xfer", last_xfer, N'(1) << vt[i].lane);
            req_valid = '0;
            chk("vec_lat1_valid", out_valid, 0);
            cycle();
            chk("vec_valid", out_valid, 1);
            chk("vec_data", out_data, vt[i].exp);
            chk("vec_tag", out_tag, vt[i].lane);
            if (i == 0) begin
                // Pointer now sits at lane 3: of lanes 0 and 3, lane 3 wins.
                req_valid = 4'b1001;
                #1;
                chk("ptr_after_lane2", req_ready, 4'b1000);
                req_valid = '0;
            end
            cycle();
        end

        // Fairness: all lanes request continuously.
        do_reset();
        for (int k = 0; k < N; k++) begin
            la[k] = W'(k);
            lb[k] = 14'h0010;
        end
        req_valid = '1;
        cycle();
        cycle();
        for (int i = 0; i < 6; i++) begin
            chk("rr_valid", out_valid, 1);
            chk("rr_tag", out_tag, i % 4);
            chk("rr_data", out_data, 14'h0010 + i % 4);
            cycle();
        end

        // Backpressure: three blocked cycles mid-stream.
        repeat (2) cycle();
        out_ready = 1'b0;
        #1;
        chk("stall_ready", req_ready, 0);
        repeat (3) begin
            cycle();
            chk("stall_ready_hold", req_ready, 0);
        end
        out_ready = 1'b1;
        repeat (6) cycle();
        drain();

        // Reset mid-stream with both stages full.
        req_valid = '1;
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        req_valid = '0;
        chk("midrst_valid", out_valid, 0);
        la[0] = 14'h0100;
        lb[0] = 14'h0023;
        req_valid = 4'b0001;
        #1;
        chk("midrst_ptr0", req_ready, 4'b0001);
        cycle();
        req_valid = '0;
        chk("midrst_lat1", out_valid, 0);
        cycle();
        chk("midrst_valid2", out_valid, 1);
        chk("midrst_data", out_data, 14'h0123);
        chk("midrst_tag", out_tag, 0);
        drain();

        // Sparse: pointer at 2, lanes 1 and 3 requesting.
        do_reset();
        req_valid = 4'b0010;
        cycle();
        req_valid = 4'b1010;
        #1;
        chk("sparse_first", req_ready, 4'b1000);
        cycle();
        req_valid = 4'b0010;
        #1;
        chk("sparse_second", req_ready, 4'b0010);
        cycle();
        drain();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < N; k++) begin
                if (last_xfer[k] || !req_valid[k]) begin
                    req_valid[k] = ($urandom_range(0, 2) != 0);
                    la[k]        = W'($urandom);
                    lb[k]        = W'($urandom);
                end
            end
            cycle();
        end
        reset = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
